// File: rtl/subgraph_feature_handler.sv
// Walks the subgraph-index BRAM, re-encodes each node's output features as sparse {value, column} H words.
// Optional saturating quantisation is enabled by defining SUBGRAPH_HANDLER_SAT_EN.
module subgraph_feature_handler #(
    parameter int DATA_WIDTH         = 8,
    parameter int NEW_FEATURE_WIDTH  = 32,
    parameter int NUM_FEATURE_IN     = 1433,
    parameter int NUM_FEATURE_OUT    = 16,
    parameter int TOTAL_NODES        = 13264,
    parameter int NUM_SUBGRAPHS      = 2708,
    parameter int H_NUM_SPARSE_DATA  = 242101,
    localparam int COL_IDX_WIDTH      = $clog2(NUM_FEATURE_IN),
    localparam int SUBGRAPH_IDX_WIDTH = $clog2(TOTAL_NODES) + 2,
    localparam int H_DATA_WIDTH       = DATA_WIDTH + COL_IDX_WIDTH,
    localparam int IDX_AW             = $clog2(TOTAL_NODES),
    localparam int FEAT_AW            = $clog2(NUM_SUBGRAPHS * NUM_FEATURE_OUT),
    localparam int H_AW               = $clog2(H_NUM_SPARSE_DATA)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          subgraph_vld_i,
    output logic                          subgraph_rdy_o,
    output logic                          gat_ready,
    output logic [IDX_AW-1:0]             subgraph_bram_addrb,
    input  logic [SUBGRAPH_IDX_WIDTH-1:0] subgraph_bram_dout,
    output logic [FEAT_AW-1:0]            feat_bram_addrb,
    input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
    output logic [H_AW-1:0]               h_data_bram_addra,
    output logic [H_DATA_WIDTH-1:0]       h_data_bram_din,
    output logic                          h_data_bram_ena,
    output logic                          h_data_bram_wea
);

    localparam int NODE_W  = SUBGRAPH_IDX_WIDTH - 2;
    localparam int ENTRY_W = $clog2(TOTAL_NODES + 1);
    localparam int WR_W    = $clog2(H_NUM_SPARSE_DATA + 1);
    localparam int CNT_W   = $clog2(NUM_SUBGRAPHS + 1);
    localparam int K_W     = (NUM_FEATURE_OUT > 1) ? $clog2(NUM_FEATURE_OUT) : 1;

    localparam logic [ENTRY_W-1:0] ENTRY_END = ENTRY_W'(TOTAL_NODES);
    localparam logic [WR_W-1:0]    H_FULL    = WR_W'(H_NUM_SPARSE_DATA);
    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(NUM_SUBGRAPHS);
    localparam logic [NODE_W-1:0]  NODE_LIM  = NODE_W'(NUM_SUBGRAPHS);
    localparam logic [K_W-1:0]     K_LAST    = K_W'(NUM_FEATURE_OUT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        IDX   = 3'd1,
        DEC   = 3'd2,
        FEAT  = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t               state_q;
    logic [ENTRY_W-1:0]   entry_ptr_q;
    logic [WR_W-1:0]      wr_ptr_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 prev_end_q;
    logic [K_W-1:0]       k_q;
    logic [FEAT_AW-1:0]   feat_addr_q;
    logic                 wr_stage_q;
    logic [K_W-1:0]       wr_k_q;
    logic                 rdy_q;
    logic                 gat_q;

    logic                 ent_start;
    logic                 ent_end;
    logic [NODE_W-1:0]    ent_node;
    logic                 ent_term;
    logic                 h_wr_en;
    logic [DATA_WIDTH-1:0] q_val;

    assign ent_start = subgraph_bram_dout[SUBGRAPH_IDX_WIDTH-1];
    assign ent_end   = subgraph_bram_dout[0];
    assign ent_node  = subgraph_bram_dout[SUBGRAPH_IDX_WIDTH-2:1];

    // A zero-start entry right after a subgraph boundary marks the end of the index list.
    assign ent_term = (((entry_ptr_q == '0) || prev_end_q) && !ent_start)
                   || (cnt_q == CNT_MAX)
                   || (entry_ptr_q == ENTRY_END);

`ifdef SUBGRAPH_HANDLER_SAT_EN
    localparam logic signed [NEW_FEATURE_WIDTH-1:0] Q_MAX = NEW_FEATURE_WIDTH'(2**(DATA_WIDTH-1) - 1);
    localparam logic signed [NEW_FEATURE_WIDTH-1:0] Q_MIN = ~Q_MAX;

    always_comb begin
        q_val = feat_bram_dout[DATA_WIDTH-1:0];
        if ($signed(feat_bram_dout) > Q_MAX) begin
            q_val = Q_MAX[DATA_WIDTH-1:0];
        end else if ($signed(feat_bram_dout) < Q_MIN) begin
            q_val = Q_MIN[DATA_WIDTH-1:0];
        end
    end
`else
    assign q_val = feat_bram_dout[DATA_WIDTH-1:0];
`endif

    // The feature word arrives one cycle after its address, so the write is formed from live BRAM data.
    assign h_wr_en = wr_stage_q && (feat_bram_dout != '0) && (wr_ptr_q != H_FULL);

    assign h_data_bram_ena     = h_wr_en;
    assign h_data_bram_wea     = h_wr_en;
    assign h_data_bram_addra   = wr_ptr_q[H_AW-1:0];
    assign h_data_bram_din     = h_wr_en ? {q_val, COL_IDX_WIDTH'(wr_k_q)} : '0;
    assign subgraph_bram_addrb = entry_ptr_q[IDX_AW-1:0];
    assign feat_bram_addrb     = feat_addr_q;
    assign subgraph_rdy_o      = rdy_q;
    assign gat_ready           = gat_q;

    // Start handshake: a request is accepted on a rising edge where subgraph_vld_i and
    // subgraph_rdy_o are both high; vld is a level and must drop after gat_ready to rearm.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            entry_ptr_q <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            prev_end_q  <= 1'b0;
            k_q         <= '0;
            feat_addr_q <= '0;
            wr_stage_q  <= 1'b0;
            wr_k_q      <= '0;
            rdy_q       <= 1'b1;
            gat_q       <= 1'b0;
        end else begin
            wr_stage_q <= 1'b0;
            if (h_wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (subgraph_vld_i) begin
                        entry_ptr_q <= '0;
                        wr_ptr_q    <= '0;
                        cnt_q       <= '0;
                        prev_end_q  <= 1'b0;
                        rdy_q       <= 1'b0;
                        state_q     <= IDX;
                    end
                end
                IDX: begin
                    state_q <= DEC;
                end
                DEC: begin
                    if (ent_term) begin
                        gat_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        prev_end_q <= ent_end;
                        if (ent_end) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        if (ent_node >= NODE_LIM) begin
                            entry_ptr_q <= entry_ptr_q + 1'b1;
                            state_q     <= IDX;
                        end else begin
                            k_q         <= '0;
                            feat_addr_q <= FEAT_AW'(ent_node) * FEAT_AW'(NUM_FEATURE_OUT);
                            state_q     <= FEAT;
                        end
                    end
                end
                FEAT: begin
                    wr_stage_q <= 1'b1;
                    wr_k_q     <= k_q;
                    if (k_q == K_LAST) begin
                        state_q <= DRAIN;
                    end else begin
                        k_q         <= k_q + 1'b1;
                        feat_addr_q <= feat_addr_q + 1'b1;
                    end
                end
                DRAIN: begin
                    entry_ptr_q <= entry_ptr_q + 1'b1;
                    state_q     <= IDX;
                end
                DONE: begin
                    if (!subgraph_vld_i) begin
                        gat_q   <= 1'b0;
                        rdy_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_subgraph_feature_handler.sv
// Bench for subgraph_feature_handler: BRAM models, an entry-walking reference model and scenario tasks.
// Honours SUBGRAPH_HANDLER_SAT_EN for the expected quantisation.
module tb_subgraph_feature_handler;

    localparam int NFO        = 16;
    localparam int TOTAL      = 13264;
    localparam int NSG        = 2708;
    localparam int H_NUM      = 242101;
    localparam int H_SMALL    = 40;
    localparam int FEAT_DEPTH = NSG * NFO;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, vld, vld2;
    logic        rdy, gat, rdy2, gat2;
    logic [13:0] idx_addr, idx_addr2;
    logic [15:0] idx_dout, idx_dout2;
    logic [15:0] feat_addr, feat_addr2;
    logic [31:0] feat_dout, feat_dout2;
    logic [17:0] h_addra;
    logic [5:0]  h_addra2;
    logic [18:0] h_din, h_din2;
    logic        h_ena, h_wea, h_ena2, h_wea2;

    logic [15:0] idx_mem  [0:TOTAL-1];
    logic [31:0] feat_mem [0:FEAT_DEPTH-1];

    logic [18:0] exp_q[$];
    logic [18:0] got_data_q[$];
    int          got_addr_q[$];
    logic [18:0] got2_data_q[$];
    int          got2_addr_q[$];

    int checks = 0;
    int errors = 0;
    logic rdy_hs;

    subgraph_feature_handler dut (
        .clk(clk), .rst(rst), .subgraph_vld_i(vld), .subgraph_rdy_o(rdy), .gat_ready(gat),
        .subgraph_bram_addrb(idx_addr), .subgraph_bram_dout(idx_dout),
        .feat_bram_addrb(feat_addr), .feat_bram_dout(feat_dout),
        .h_data_bram_addra(h_addra), .h_data_bram_din(h_din),
        .h_data_bram_ena(h_ena), .h_data_bram_wea(h_wea)
    );

    subgraph_feature_handler #(.H_NUM_SPARSE_DATA(H_SMALL)) dut_small (
        .clk(clk), .rst(rst), .subgraph_vld_i(vld2), .subgraph_rdy_o(rdy2), .gat_ready(gat2),
        .subgraph_bram_addrb(idx_addr2), .subgraph_bram_dout(idx_dout2),
        .feat_bram_addrb(feat_addr2), .feat_bram_dout(feat_dout2),
        .h_data_bram_addra(h_addra2), .h_data_bram_din(h_din2),
        .h_data_bram_ena(h_ena2), .h_data_bram_wea(h_wea2)
    );

    always @(posedge clk) begin
        idx_dout   <= idx_mem[idx_addr];
        feat_dout  <= feat_mem[feat_addr];
        idx_dout2  <= idx_mem[idx_addr2];
        feat_dout2 <= feat_mem[feat_addr2];
    end

    always @(negedge clk) begin
        if (h_ena && h_wea) begin
            got_data_q.push_back(h_din);
            got_addr_q.push_back(int'(h_addra));
        end
        if (h_ena2 && h_wea2) begin
            got2_data_q.push_back(h_din2);
            got2_addr_q.push_back(int'(h_addra2));
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] q_model(input logic [31:0] v);
        int s;
        s = $signed(v);
`ifdef SUBGRAPH_HANDLER_SAT_EN
        if (s > 127) return 8'h7f;
        if (s < -128) return 8'h80;
`endif
        return v[7:0];
    endfunction

    // Walk the index list entry by entry and list every H word that should appear, in order.
    task automatic build_model(input int h_limit, output int cyc);
        int ptr, cnt, proc_n, skip_n, wr, node;
        bit prev_end;
        logic [15:0] e;
        logic [31:0] v;
        exp_q.delete();
        ptr = 0; cnt = 0; proc_n = 0; skip_n = 0; wr = 0; prev_end = 1'b1;
        while (ptr < TOTAL && cnt < NSG) begin
            e = idx_mem[ptr];
            if (prev_end && !e[15]) break;
            node = int'(e[14:1]);
            if (node >= NSG) begin
                skip_n++;
            end else begin
                proc_n++;
                for (int k = 0; k < NFO; k++) begin
                    v = feat_mem[node * NFO + k];
                    if (v != 0) begin
                        if (wr < h_limit) exp_q.push_back({q_model(v), 11'(k)});
                        wr++;
                    end
                end
            end
            if (e[0]) cnt++;
            prev_end = e[0];
            ptr++;
        end
        cyc = proc_n * (NFO + 3) + skip_n * 2 + 2;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < TOTAL; i++) idx_mem[i] = '0;
        for (int i = 0; i < FEAT_DEPTH; i++) feat_mem[i] = '0;
    endtask

    task automatic set_entry(input int i, input bit s, input int node, input bit e);
        idx_mem[i] = {s, 14'(node), e};
    endtask

    task automatic load_common();
        clear_mem();
        for (int i = 0; i < 80; i++) feat_mem[i] = 32'(i + 1);
        set_entry(0, 1, 2, 0); set_entry(1, 0, 6, 0); set_entry(2, 0, 8, 0); set_entry(3, 0, 10, 1);
        set_entry(4, 1, 0, 0); set_entry(5, 0, 4, 1);
        set_entry(6, 1, 1, 0); set_entry(7, 0, 3, 0); set_entry(8, 0, 5, 0); set_entry(9, 0, 7, 1);
    endtask

    task automatic run_dut(output int cyc, output bit timed_out);
        got_data_q.delete();
        got_addr_q.delete();
        vld = 1'b1;
        @(posedge clk); #1;
        rdy_hs = rdy;
        cyc = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (gat) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic end_run();
        vld = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b expected 1", rdy); end
        checks++; if (gat !== 1'b0) begin errors++; $display("FAIL reset_gat: got %b expected 0", gat); end
        checks++; if (idx_addr !== '0) begin errors++; $display("FAIL reset_idx_addr: got %h expected 0", idx_addr); end
        checks++; if (feat_addr !== '0) begin errors++; $display("FAIL reset_feat_addr: got %h expected 0", feat_addr); end
        checks++; if (h_addra !== '0) begin errors++; $display("FAIL reset_h_addr: got %h expected 0", h_addra); end
        checks++; if (h_din !== '0) begin errors++; $display("FAIL reset_h_din: got %h expected 0", h_din); end
        checks++; if (h_ena !== 1'b0 || h_wea !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b%b expected 00", h_ena, h_wea); end
        checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL reset_rdy_small: got %b expected 1", rdy2); end
    endtask

    task automatic test_common();
        int cyc, exp_cyc;
        bit to;
        load_common();
        build_model(H_NUM, exp_cyc);
        run_dut(cyc, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL common_timeout: gat_ready never rose"); end
        checks++; if (rdy_hs !== 1'b0) begin errors++; $display("FAIL common_rdy_drop: got %b expected 0", rdy_hs); end
        checks++; if (cyc !== 192) begin errors++; $display("FAIL common_latency: got %0d expected 192", cyc); end
        checks++; if (got_data_q.size() !== 80) begin errors++; $display("FAIL common_count: got %0d expected 80", got_data_q.size()); end
        for (int i = 0; i < 16 && i < got_data_q.size(); i++) begin
            checks++;
            if (got_data_q[i] !== {8'(33 + i), 11'(i)}) begin
                errors++; $display("FAIL common_h%0d: got %h expected %h", i, got_data_q[i], {8'(33 + i), 11'(i)});
            end
        end
        for (int i = 0; i < exp_q.size() && i < got_data_q.size(); i++) begin
            checks++;
            if (got_data_q[i] !== exp_q[i] || got_addr_q[i] !== i) begin
                errors++; $display("FAIL common_word%0d: got %h@%0d expected %h@%0d", i, got_data_q[i], got_addr_q[i], exp_q[i], i);
            end
        end
        end_run();
        checks++; if (rdy !== 1'b1 || gat !== 1'b0) begin errors++; $display("FAIL common_idle: got rdy %b gat %b expected 1 0", rdy, gat); end
    endtask

    task automatic test_done_hold();
        int cyc;
        bit to;
        load_common();
        run_dut(cyc, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL hold_timeout: gat_ready never rose"); end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checks++;
            if (gat !== 1'b1 || rdy !== 1'b0) begin errors++; $display("FAIL hold_gat: got gat %b rdy %b expected 1 0", gat, rdy); end
        end
        vld = 1'b0;
        @(posedge clk); #1;
        checks++; if (gat !== 1'b0 || rdy !== 1'b1) begin errors++; $display("FAIL hold_release: got gat %b rdy %b expected 0 1", gat, rdy); end
    endtask

    task automatic test_quant();
        int cyc;
        bit to;
        logic [7:0] e0, e1;
`ifdef SUBGRAPH_HANDLER_SAT_EN
        e0 = 8'd127; e1 = 8'h80;
`else
        e0 = 8'd44;  e1 = 8'h38;
`endif
        clear_mem();
        feat_mem[0] = 32'd300;
        feat_mem[1] = 32'hFFFF_FF38;
        feat_mem[2] = 32'd5;
        set_entry(0, 1, 0, 1);
        run_dut(cyc, to);
        checks++; if (to !== 1'b0 || cyc !== 21) begin errors++; $display("FAIL quant_latency: got %0d expected 21", cyc); end
        checks++; if (got_data_q.size() !== 3) begin errors++; $display("FAIL quant_count: got %0d expected 3", got_data_q.size()); end
        if (got_data_q.size() == 3) begin
            checks++; if (got_data_q[0] !== {e0, 11'd0}) begin errors++; $display("FAIL quant_pos: got %h expected %h", got_data_q[0], {e0, 11'd0}); end
            checks++; if (got_data_q[1] !== {e1, 11'd1}) begin errors++; $display("FAIL quant_neg: got %h expected %h", got_data_q[1], {e1, 11'd1}); end
            checks++; if (got_data_q[2] !== {8'd5, 11'd2}) begin errors++; $display("FAIL quant_small: got %h expected %h", got_data_q[2], {8'd5, 11'd2}); end
        end
        end_run();
    endtask

    task automatic test_skip();
        int cyc, exp_cyc;
        bit to;
        clear_mem();
        for (int k = 0; k < NFO; k++) feat_mem[NFO + k] = 32'($urandom_range(1, 255));
        set_entry(0, 1, 3000, 0);
        set_entry(1, 0, 1, 1);
        build_model(H_NUM, exp_cyc);
        run_dut(cyc, to);
        checks++; if (to !== 1'b0 || cyc !== 23) begin errors++; $display("FAIL skip_latency: got %0d expected 23", cyc); end
        checks++; if (got_data_q.size() !== NFO) begin errors++; $display("FAIL skip_count: got %0d expected %0d", got_data_q.size(), NFO); end
        for (int i = 0; i < exp_q.size() && i < got_data_q.size(); i++) begin
            checks++;
            if (got_data_q[i] !== exp_q[i]) begin errors++; $display("FAIL skip_word%0d: got %h expected %h", i, got_data_q[i], exp_q[i]); end
        end
        end_run();
    endtask

    task automatic test_reset_mid();
        int cyc, exp_cyc;
        bit to;
        load_common();
        got_data_q.delete();
        got_addr_q.delete();
        vld = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        vld = 1'b0;
        @(posedge clk); #1;
        checks++; if (rdy !== 1'b1 || gat !== 1'b0) begin errors++; $display("FAIL rstmid_state: got rdy %b gat %b expected 1 0", rdy, gat); end
        checks++; if (got_data_q.size() !== 3) begin errors++; $display("FAIL rstmid_prewrites: got %0d expected 3", got_data_q.size()); end
        got_data_q.delete();
        got_addr_q.delete();
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        checks++; if (got_data_q.size() !== 0 || rdy !== 1'b1) begin errors++; $display("FAIL rstmid_quiet: got %0d writes rdy %b expected 0 1", got_data_q.size(), rdy); end
        build_model(H_NUM, exp_cyc);
        run_dut(cyc, to);
        checks++; if (to !== 1'b0 || cyc !== exp_cyc) begin errors++; $display("FAIL rstmid_latency: got %0d expected %0d", cyc, exp_cyc); end
        checks++; if (got_data_q.size() !== exp_q.size()) begin errors++; $display("FAIL rstmid_count: got %0d expected %0d", got_data_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_data_q.size(); i++) begin
            checks++;
            if (got_data_q[i] !== exp_q[i] || got_addr_q[i] !== i) begin
                errors++; $display("FAIL rstmid_word%0d: got %h@%0d expected %h@%0d", i, got_data_q[i], got_addr_q[i], exp_q[i], i);
            end
        end
        end_run();
    endtask

    task automatic test_random();
        int cyc, exp_cyc, ptr, nsub, len, node, t;
        bit to;
        for (int it = 0; it < 4; it++) begin
            clear_mem();
            for (int w = 0; w < 20 * NFO; w++) begin
                case ($urandom_range(0, 2))
                    0: feat_mem[w] = '0;
                    1: begin t = int'($urandom_range(0, 400)) - 200; feat_mem[w] = 32'(t); end
                    default: feat_mem[w] = $urandom;
                endcase
            end
            ptr = 0;
            nsub = $urandom_range(1, 3);
            for (int s = 0; s < nsub; s++) begin
                len = $urandom_range(1, 3);
                for (int j = 0; j < len; j++) begin
                    node = ($urandom_range(0, 5) == 0) ? NSG + int'($urandom_range(0, 3000)) : int'($urandom_range(0, 19));
                    set_entry(ptr, j == 0, node, j == len - 1);
                    ptr++;
                end
            end
            build_model(H_NUM, exp_cyc);
            run_dut(cyc, to);
            checks++; if (to !== 1'b0 || cyc !== exp_cyc) begin errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", it, cyc, exp_cyc); end
            checks++; if (got_data_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand%0d_count: got %0d expected %0d", it, got_data_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_data_q.size(); i++) begin
                checks++;
                if (got_data_q[i] !== exp_q[i] || got_addr_q[i] !== i) begin
                    errors++; $display("FAIL rand%0d_word%0d: got %h@%0d expected %h@%0d", it, i, got_data_q[i], got_addr_q[i], exp_q[i], i);
                end
            end
            end_run();
        end
    endtask

    task automatic test_full();
        int cyc, exp_cyc;
        bit to;
        load_common();
        build_model(H_SMALL, exp_cyc);
        got2_data_q.delete();
        got2_addr_q.delete();
        vld2 = 1'b1;
        @(posedge clk); #1;
        cyc = 0;
        to = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (gat2) begin to = 1'b0; break; end
        end
        checks++; if (to !== 1'b0 || cyc !== exp_cyc) begin errors++; $display("FAIL full_latency: got %0d expected %0d", cyc, exp_cyc); end
        checks++; if (got2_data_q.size() !== H_SMALL) begin errors++; $display("FAIL full_count: got %0d expected %0d", got2_data_q.size(), H_SMALL); end
        checks++; if (h_addra2 !== 6'(H_SMALL)) begin errors++; $display("FAIL full_ptr_hold: got %0d expected %0d", h_addra2, H_SMALL); end
        for (int i = 0; i < exp_q.size() && i < got2_data_q.size(); i++) begin
            checks++;
            if (got2_data_q[i] !== exp_q[i] || got2_addr_q[i] !== i) begin
                errors++; $display("FAIL full_word%0d: got %h@%0d expected %h@%0d", i, got2_data_q[i], got2_addr_q[i], exp_q[i], i);
            end
        end
        vld2 = 1'b0;
        @(posedge clk); #1;
        checks++; if (rdy2 !== 1'b1 || gat2 !== 1'b0) begin errors++; $display("FAIL full_idle: got rdy %b gat %b expected 1 0", rdy2, gat2); end
    endtask

    initial begin
        rst  = 1'b1;
        vld  = 1'b0;
        vld2 = 1'b0;
        clear_mem();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_common();
        test_done_hold();
        test_quant();
        test_skip();
        test_reset_mid();
        test_random();
        test_full();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
